bram2_be_pipe: RTL and testbench

- Single-clock, true dual-port block RAM with per-byte write enables.
- Read latency is configurable from 1 to 3 cycles, and each port has an output-valid strobe.
- Mixed-port collision handling is defined by parameter.
- Successor to the plain dual-port BRAM wrapper, used under BSV BRAM server interfaces that need byte-masked writes and a known response timing.

---
 rtl/bram2_be_pipe_if.sv | 41 ++++
 rtl/bram2_be_pipe.sv | 125 ++++++++++++
 tb/tb_bram2_be_pipe.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bram2_be_pipe_if.sv
// Bus bundle for the dual-port byte-enable BRAM.
// Carries both request ports (en/we/addr/di) and both response ports
// (do/do_valid). The master modport drives requests and receives
// responses; the slave modport is the RAM side.
//   ena/enb         port request
//   wea/web         per-lane write enables, all-zero means read
//   addra/addrb     word address
//   dia/dib         write data
//   doa/dob         registered read data
//   doa_valid/...   read result strobe
interface bram2_be_pipe_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
);
    localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;

    logic                  ena;
    logic [NBYTES-1:0]     wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dia;
    logic [DATA_WIDTH-1:0] doa;
    logic                  doa_valid;

    logic                  enb;
    logic [NBYTES-1:0]     web;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] dib;
    logic [DATA_WIDTH-1:0] dob;
    logic                  dob_valid;

    modport master (
        output ena, wea, addra, dia, enb, web, addrb, dib,
        input  doa, doa_valid, dob, dob_valid
    );

    modport slave (
        input  ena, wea, addra, dia, enb, web, addrb, dib,
        output doa, doa_valid, dob, dob_valid
    );
endinterface

// File: rtl/bram2_be_pipe.sv
// True dual-port block RAM with per-byte write enables and a configurable
// 1..3 cycle registered read pipeline with a valid strobe per port.
// Ports:
//   clk   sole clock for both ports
//   rst   asynchronous, active-high reset of the read pipelines/outputs
//   bus   bram2_be_pipe_if slave modport (requests in, responses out)
// The array itself is never reset. Out-of-range writes are dropped and
// out-of-range reads return zero on schedule.
module bram2_be_pipe #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MEMSIZE    = 1024,
    parameter int LATENCY    = 1,
    parameter int RDW_MIXED  = 0
) (
    input logic            clk,
    input logic            rst,
    bram2_be_pipe_if.slave bus
);
    localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(MEMSIZE);

    if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
        $error("bram2_be_pipe: LATENCY must be 1, 2 or 3");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("bram2_be_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (MEMSIZE > (2 ** ADDR_WIDTH)) begin : g_bad_size
        $error("bram2_be_pipe: MEMSIZE exceeds address space");
    end

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [NBYTES-1:0]     be
    );
        logic [DATA_WIDTH-1:0] r;
        r = base;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) r[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:MEMSIZE-1];

    logic                  in_a, in_b, rd_a, rd_b, wr_a, wr_b, same_addr;
    logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

    assign in_a      = ({1'b0, bus.addra} < ADDR_LIMIT);
    assign in_b      = ({1'b0, bus.addrb} < ADDR_LIMIT);
    assign rd_a      = bus.ena && (bus.wea == '0);
    assign rd_b      = bus.enb && (bus.web == '0);
    // Writes are gated by rst so nothing lands in the array while reset is held.
    assign wr_a      = bus.ena && (bus.wea != '0) && in_a && !rst;
    assign wr_b      = bus.enb && (bus.web != '0) && in_b && !rst;
    assign same_addr = (bus.addra == bus.addrb);

    // Same-address double write: B lanes first, then A lanes on top so A wins.
    always_ff @(posedge clk) begin
        if (wr_a && wr_b && same_addr) begin
            mem[bus.addra] <= merge_lanes(merge_lanes(mem[bus.addra], bus.dib, bus.web),
                                          bus.dia, bus.wea);
        end else begin
            if (wr_a) mem[bus.addra] <= merge_lanes(mem[bus.addra], bus.dia, bus.wea);
            if (wr_b) mem[bus.addrb] <= merge_lanes(mem[bus.addrb], bus.dib, bus.web);
        end
    end

    // Read word as seen at the accept edge; optional bypass of the other
    // port's same-cycle write lanes when new-data collision mode is chosen.
    always_comb begin
        rdata_a = '0;
        if (in_a) begin
            rdata_a = mem[bus.addra];
            if (RDW_MIXED != 0 && wr_b && same_addr)
                rdata_a = merge_lanes(rdata_a, bus.dib, bus.web);
        end
    end

    always_comb begin
        rdata_b = '0;
        if (in_b) begin
            rdata_b = mem[bus.addrb];
            if (RDW_MIXED != 0 && wr_a && same_addr)
                rdata_b = merge_lanes(rdata_b, bus.dia, bus.wea);
        end
    end

    // Read pipelines: stage 0 loads at the accept edge, the last stage is
    // the output register. Data stages only load behind a valid entry so the
    // output holds its last result between pulses.
    logic [LATENCY-1:0]    va_q, vb_q;
    logic [DATA_WIDTH-1:0] da_q [LATENCY];
    logic [DATA_WIDTH-1:0] db_q [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            va_q <= '0;
            vb_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                da_q[i] <= '0;
                db_q[i] <= '0;
            end
        end else begin
            va_q[0] <= rd_a;
            vb_q[0] <= rd_b;
            if (rd_a) da_q[0] <= rdata_a;
            if (rd_b) db_q[0] <= rdata_b;
            for (int i = 1; i < LATENCY; i++) begin
                va_q[i] <= va_q[i-1];
                vb_q[i] <= vb_q[i-1];
                if (va_q[i-1]) da_q[i] <= da_q[i-1];
                if (vb_q[i-1]) db_q[i] <= db_q[i-1];
            end
        end
    end

    assign bus.doa       = da_q[LATENCY-1];
    assign bus.doa_valid = va_q[LATENCY-1];
    assign bus.dob       = db_q[LATENCY-1];
    assign bus.dob_valid = vb_q[LATENCY-1];
endmodule

// File: tb/tb_bram2_be_pipe.sv
// Directed bench for bram2_be_pipe. Four instances cover the parameter
// corners: d1 (latency 1, old-data collisions, MEMSIZE 1000), d1m (latency
// 1, new-data collisions), d2 (latency 2) and d3 (latency 3).
module tb_bram2_be_pipe;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bram2_be_pipe_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8)) i1 ();
    bram2_be_pipe_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8)) i1m ();
    bram2_be_pipe_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8)) i2 ();
    bram2_be_pipe_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8)) i3 ();

    bram2_be_pipe #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8), .MEMSIZE(1000),
                    .LATENCY(1), .RDW_MIXED(0)) d1 (.clk(clk), .rst(rst), .bus(i1));
    bram2_be_pipe #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8), .MEMSIZE(1024),
                    .LATENCY(1), .RDW_MIXED(1)) d1m (.clk(clk), .rst(rst), .bus(i1m));
    bram2_be_pipe #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8), .MEMSIZE(1024),
                    .LATENCY(2), .RDW_MIXED(0)) d2 (.clk(clk), .rst(rst), .bus(i2));
    bram2_be_pipe #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8), .MEMSIZE(1024),
                    .LATENCY(3), .RDW_MIXED(0)) d3 (.clk(clk), .rst(rst), .bus(i3));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        i1.ena = 0;  i1.wea = '0;  i1.addra = '0;  i1.dia = '0;
        i1.enb = 0;  i1.web = '0;  i1.addrb = '0;  i1.dib = '0;
        i1m.ena = 0; i1m.wea = '0; i1m.addra = '0; i1m.dia = '0;
        i1m.enb = 0; i1m.web = '0; i1m.addrb = '0; i1m.dib = '0;
        i2.ena = 0;  i2.wea = '0;  i2.addra = '0;  i2.dia = '0;
        i2.enb = 0;  i2.web = '0;  i2.addrb = '0;  i2.dib = '0;
        i3.ena = 0;  i3.wea = '0;  i3.addra = '0;  i3.dia = '0;
        i3.enb = 0;  i3.web = '0;  i3.addrb = '0;  i3.dib = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        step();
        step();
        check("rst_d1_doa", i1.doa, 32'h0);
        check("rst_d1_doa_valid", i1.doa_valid, 32'h0);
        check("rst_d1_dob_valid", i1.dob_valid, 32'h0);
        check("rst_d3_doa", i3.doa, 32'h0);
        rst = 1'b0;
        step();

        // Write on A, read on B next cycle, latency 1.
        i1.ena = 1; i1.wea = 4'hF; i1.addra = 10'd5; i1.dia = 32'hDEADBEEF;
        step();
        check("wr_no_valid", i1.doa_valid, 32'h0);
        i1.ena = 0; i1.wea = '0;
        i1.enb = 1; i1.web = '0; i1.addrb = 10'd5;
        step();
        i1.enb = 0;
        check("l1_dob", i1.dob, 32'hDEADBEEF);
        check("l1_dob_valid", i1.dob_valid, 32'h1);
        step();
        check("l1_dob_valid_drop", i1.dob_valid, 32'h0);
        check("l1_dob_hold", i1.dob, 32'hDEADBEEF);

        // Byte-masked update: lanes 0 and 2 replaced.
        i1.ena = 1; i1.wea = 4'hF; i1.addra = 10'd7; i1.dia = 32'h11223344;
        step();
        i1.wea = 4'b0101; i1.dia = 32'hAABBCCDD;
        step();
        i1.wea = '0;
        step();
        i1.ena = 0;
        check("byte_mask", i1.doa, 32'h11BB33DD);

        // Write-write at addr 4 over zero: lane 0 A only (AA), lane 1 on both
        // ports so A's 00 wins, lane 2 B only (BB), lane 3 untouched.
        i1.ena = 1; i1.wea = 4'hF; i1.addra = 10'd4; i1.dia = 32'h0;
        step();
        i1.wea = 4'b0011; i1.dia = 32'h000000AA;
        i1.enb = 1; i1.web = 4'b0110; i1.addrb = 10'd4; i1.dib = 32'hBBBBBBBB;
        step();
        i1.enb = 0; i1.web = '0;
        i1.wea = '0;
        step();
        i1.ena = 0;
        check("ww_collision", i1.doa, 32'h00BB00AA);

        // Out-of-range (MEMSIZE=1000): write ignored, read gives 0 with valid.
        i1.ena = 1; i1.wea = 4'hF; i1.addra = 10'd0; i1.dia = 32'h12345678;
        step();
        i1.addra = 10'd1000; i1.dia = 32'hFFFFFFFF;
        step();
        i1.wea = '0;
        i1.enb = 1; i1.web = '0; i1.addrb = 10'd0;
        step();
        i1.ena = 0; i1.enb = 0;
        check("oor_doa", i1.doa, 32'h0);
        check("oor_doa_valid", i1.doa_valid, 32'h1);
        check("oor_addr0", i1.dob, 32'h12345678);

        // Mixed-port collision at addr 9, old-data vs new-data instances.
        i1.ena = 1;  i1.wea = 4'hF;  i1.addra = 10'd9;  i1.dia = 32'h0;
        i1m.ena = 1; i1m.wea = 4'hF; i1m.addra = 10'd9; i1m.dia = 32'h0;
        step();
        i1.dia = 32'h5A5A5A5A; i1m.dia = 32'h5A5A5A5A;
        i1.enb = 1;  i1.web = '0;  i1.addrb = 10'd9;
        i1m.enb = 1; i1m.web = '0; i1m.addrb = 10'd9;
        step();
        check("rdw_old", i1.dob, 32'h0);
        check("rdw_new", i1m.dob, 32'h5A5A5A5A);
        i1m.wea = 4'b0001; i1m.dia = 32'h000000FF;
        i1.ena = 0; i1.enb = 0;
        step();
        check("rdw_new_lane", i1m.dob, 32'h5A5A5AFF);
        // Reverse direction: B writes lane 3, A reads.
        i1m.wea = '0; i1m.addra = 10'd9;
        i1m.web = 4'b1000; i1m.dib = 32'h11000000;
        step();
        i1m.ena = 0; i1m.enb = 0; i1m.web = '0;
        check("rdw_new_rev", i1m.doa, 32'h115A5AFF);

        // Latency 3 pipelined reads of preloaded 10..13.
        for (int k = 0; k < 4; k++) begin
            i3.ena = 1; i3.wea = 4'hF; i3.addra = 10'(k); i3.dia = 32'(10 + k);
            step();
        end
        i3.wea = '0;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                i3.ena = 1; i3.addra = 10'(k);
            end else begin
                i3.ena = 0;
            end
            step();
            check($sformatf("l3_valid_%0d", k), i3.doa_valid, 32'((k >= 2) && (k <= 5)));
            if (k >= 2 && k <= 5) check($sformatf("l3_data_%0d", k), i3.doa, 32'(10 + k - 2));
        end
        check("l3_hold", i3.doa, 32'd13);

        // Latency 2: reset one cycle after a read, held two cycles, with a
        // write presented during reset that must be ignored.
        i2.ena = 1; i2.wea = 4'hF; i2.addra = 10'd20; i2.dia = 32'hCAFEF00D;
        step();
        i2.wea = '0;
        step();
        i2.ena = 0;
        rst = 1'b1;
        #1;
        check("mid_rst_doa", i2.doa, 32'h0);
        check("mid_rst_valid", i2.doa_valid, 32'h0);
        i2.ena = 1; i2.wea = 4'hF; i2.addra = 10'd20; i2.dia = 32'hFFFFFFFF;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("rst_hold_valid_%0d", k), i2.doa_valid, 32'h0);
            check($sformatf("rst_hold_doa_%0d", k), i2.doa, 32'h0);
        end
        rst = 1'b0;
        i2.ena = 0; i2.wea = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("post_rst_valid_%0d", k), i2.doa_valid, 32'h0);
        end
        i2.ena = 1; i2.addra = 10'd20;
        step();
        i2.ena = 0;
        check("l2_first_edge", i2.doa_valid, 32'h0);
        step();
        check("l2_valid", i2.doa_valid, 32'h1);
        check("l2_rst_write_ignored", i2.doa, 32'hCAFEF00D);
        step();
        check("l2_valid_drop", i2.doa_valid, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
